logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

Parametrised, pipelined bitwise logic unit: the multi-bit, multi-function successor to the processor's single AND2 gate. Accepts two WIDTH-bit operands plus a 3-bit opcode over a valid/ready handshake. Produces a registered result with zero and parity flags two cycles later, with full backpressure support. Sits in the execute stage beside the adder as the logical-op functional unit.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  unit can accept a beat this cycle
- in_op  input  3  function select (see Operation)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts result
- out_result  output  WIDTH  registered result
- out_zero  output  1  out_result == 0
- out_parity  output  1  XOR-reduction of out_result (1 = odd number of ones)

## Operation
- Opcodes: 0 AND a&b; 1 OR a|b; 2 XOR a^b; 3 NAND ~(a&b); 4 NOR ~(a|b); 5 XNOR ~(a^b); 6 ANDN a&~b; 7 RAND = {WIDTH-1 zeros, &a} (in_b ignored).
- Stage 1 (S1): registers in_a, in_b, in_op, s1_valid on accept (in_valid && in_ready).
- Stage 2 (S2): computes function of S1 contents, registers out_result, out_zero, out_parity, out_valid.
- Advance rules: s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational from out_ready and registered valids only, no dependence on in_valid).
- S2 loads when s2_adv: out_valid <= s1_valid; data updates only when s1_valid (bubbles do not overwrite data).
- S1 loads when s1_adv: s1_valid <= in_valid; data captured only when in_valid.
- Stall: out_valid && !out_ready holds out_result/out_zero/out_parity/out_valid bit-stable; S1 holds if also full; in_ready drops only when both stages are full and out_ready is low.
- No beat is dropped or duplicated; order is strictly preserved.
- Flags always describe the currently presented out_result, never a different beat.

## Timing
- Reset (async assert, sync-safe deassert): s1_valid=0, out_valid=0, out_result=0, out_zero=1, out_parity=0, S1 data regs=0. in_ready=1 whenever rst is low after reset (both stages empty).
- Reset mid-operation: all in-flight beats discarded immediately; no out_valid pulse after deassert until a new beat is accepted.
- Latency: beat accepted at edge N → out_valid=1 with its result after edge N+1 (visible in cycle N+1 to N+2), i.e. 2 clock edges.
- Throughput: 1 beat/cycle with out_ready held high; bubbles in input produce identical bubbles at output.
- Simultaneous out handshake and input accept with both stages full: legal, all stages shift, in_ready stays 1.
- Width rules: all ops bitwise over WIDTH; no carries; RAND upper bits exactly zero.

## Test plan
- Reset: assert rst mid-stream with two beats in flight → out_valid=0, out_result=0x00, out_zero=1, out_parity=0 immediately; no stale beat after release (WIDTH=8).
- All opcodes, WIDTH=8, a=0xF0, b=0xCC, out_ready=1 → results 0xC0,0xFC,0x3C,0x3F,0x03,0xC3,0x30, and RAND=0x00; then a=0xFF op7 → 0x01, parity=1, zero=0.
- Latency/throughput: 8 back-to-back beats with out_ready=1 → first out_valid exactly 2 edges after first accept, then 8 consecutive valid cycles in order.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 → exactly 2 beats accepted, in_ready=0 thereafter, out_result stable; release → remaining beats drain in order, none lost or duplicated.
- Flags: a=0xAA, b=0x55 AND → result 0x00, zero=1, parity=0; XOR → 0xFF, zero=0, parity=0; a=0x07,b=0x00 OR → 0x07, parity=1.
- Random stress: random in_valid/out_ready at 50% over 10k beats vs scoreboard model; ordering, values, and flags all match.

Source files
------------

// File: rtl/logic_unit_pipe_if.sv
// Operand/result bus for the pipelined logic unit.
//
// Handshake (both directions): a beat moves on a rising clock edge exactly
// when valid && ready are both high at that edge. A producer holds valid
// and its payload stable until the beat moves. in_ready never depends on
// in_valid, and out_valid never depends on out_ready.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_parity;

    // Side that issues operands and consumes results (execute-stage control).
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_parity
    );

    // The logic unit itself.
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_parity
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit. S1 holds the accepted operands,
// S2 holds the registered result plus zero/parity flags. Each stage
// advances when it is empty or when the stage after it is moving, which
// gives full throughput with out_ready high and lossless backpressure.
module logic_unit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    logic_unit_pipe_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_RAND = 3'd7
    } op_e;

    // Stage 1: captured operands.
    logic             s1_valid;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    // Stage 2: presented result.
    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic             out_zero_q;
    logic             out_parity_q;

    // Advance enables and the combinational function of S1.
    logic             s2_adv;
    logic             s1_adv;
    logic [WIDTH-1:0] fn_result;

    // S2 moves when it is empty or its beat is being taken downstream;
    // S1 moves when it is empty or S2 is moving. in_ready is built only
    // from registered valids and out_ready.
    always_comb begin
        s2_adv = !out_valid_q || bus.out_ready;
        s1_adv = !s1_valid || s2_adv;
    end

    // Bitwise function selected by the S1 opcode; RAND reduces operand A
    // into bit 0 and forces every upper bit to zero.
    always_comb begin
        fn_result = '0;
        case (s1_op)
            OP_AND:  fn_result = s1_a & s1_b;
            OP_OR:   fn_result = s1_a | s1_b;
            OP_XOR:  fn_result = s1_a ^ s1_b;
            OP_NAND: fn_result = ~(s1_a & s1_b);
            OP_NOR:  fn_result = ~(s1_a | s1_b);
            OP_XNOR: fn_result = ~(s1_a ^ s1_b);
            OP_ANDN: fn_result = s1_a & ~s1_b;
            OP_RAND: fn_result[0] = &s1_a;
            default: fn_result = '0;
        endcase
    end

    // Stage 1 register: valid follows in_valid on every advance, operand
    // data is only overwritten by a real beat so bubbles leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_AND;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op <= op_e'(bus.in_op);
                s1_a  <= bus.in_a;
                s1_b  <= bus.in_b;
            end
        end
    end

    // Stage 2 register: result and both flags load together from the same
    // S1 beat so the flags always describe the presented result. A stall
    // (out_valid && !out_ready) keeps every output bit stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_zero_q   <= 1'b1;
            out_parity_q <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_result_q <= fn_result;
                out_zero_q   <= ~|fn_result;
                out_parity_q <= ^fn_result;
            end
        end
    end

    assign bus.in_ready   = s1_adv;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.out_parity = out_parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe at WIDTH=8: reset, every opcode,
// latency/throughput, backpressure, flags and a randomised stress run.
module tb_logic_unit_pipe;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic_unit_pipe_if #(.WIDTH(W)) bus ();

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    logic [W+1:0] exp_q[$];   // {result, zero, parity}

    // Opcode table for a=0xF0, b=0xCC, hand computed.
    logic [W-1:0] op_exp [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30, 8'h00};
    // Backpressure beats: XOR with 0x0F.
    logic [W-1:0] bp_a   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [W-1:0] bp_res [4] = '{8'h1E, 8'h2D, 8'h3C, 8'h4B};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [W+1:0] pack(input logic [W-1:0] r, input logic z, input logic p);
        return {r, z, p};
    endfunction

    // Reference model: per-bit truth table indexed by {a_bit, b_bit}.
    function automatic logic [W+1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [3:0]   tt;
        logic [W-1:0] r;
        int           ones;
        case (op)
            3'd0: tt = 4'b1000;
            3'd1: tt = 4'b1110;
            3'd2: tt = 4'b0110;
            3'd3: tt = 4'b0111;
            3'd4: tt = 4'b0001;
            3'd5: tt = 4'b1001;
            3'd6: tt = 4'b0100;
            default: tt = 4'b0000;
        endcase
        for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
        if (op == 3'd7) begin
            r    = '0;
            r[0] = &a;
        end
        ones = 0;
        for (int i = 0; i < W; i++) ones += int'(r[i]);
        return {r, (r == '0), ones[0]};
    endfunction

    // Output monitor: every completed output handshake is checked in order.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check("unexpected_out", {22'd0, bus.out_result, bus.out_zero, bus.out_parity}, 32'hFFFF_FFFF);
            else check("out_beat", {22'd0, bus.out_result, bus.out_zero, bus.out_parity}, {22'd0, exp_q.pop_front()});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W+1:0] exp, output int acc_cyc);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        acc_cyc      = -1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(exp);
                acc_cyc = cyc;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic observe(output int t_first, output int run);
        bit gap = 1'b0;
        t_first = -1;
        run     = 0;
        for (int t = 0; t < 30 && t_first < 0; t++) begin
            @(negedge clk);
            if (bus.out_valid) t_first = cyc;
        end
        if (t_first >= 0) begin
            run = 1;
            for (int k = 1; k < 8; k++) begin
                @(negedge clk);
                if (!bus.out_valid) gap = 1'b1;
                if (!gap) run++;
            end
            @(negedge clk);
            check("lat_bubble_after", bus.out_valid, 1'b0);
        end
    endtask

    // ---------------- main sequence ----------------
    int c;
    int acc0;
    int t_first;
    int run;
    int acc;
    int k;
    int out_base;
    bit rnd_done;
    logic [2:0]   r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] v;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready",   bus.in_ready,   1'b1);
        check("rst_out_valid",  bus.out_valid,  1'b0);
        check("rst_out_result", bus.out_result, 8'h00);
        check("rst_out_zero",   bus.out_zero,   1'b1);
        check("rst_out_parity", bus.out_parity, 1'b0);
        @(posedge clk);
        #1;

        // Reset with two beats in flight
        send(3'd0, 8'hF0, 8'hCC, pack(8'hC0, 1'b0, 1'b0), c);
        send(3'd1, 8'hF0, 8'hCC, pack(8'hFC, 1'b0, 1'b0), c);
        idle();
        @(negedge clk);
        check("pre_rst_valid",    bus.out_valid,  1'b1);
        check("pre_rst_result",   bus.out_result, 8'hC0);
        check("pre_rst_in_ready", bus.in_ready,   1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_out_valid",  bus.out_valid,  1'b0);
        check("midrst_out_result", bus.out_result, 8'h00);
        check("midrst_out_zero",   bus.out_zero,   1'b1);
        check("midrst_out_parity", bus.out_parity, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("postrst_no_valid", bus.out_valid, 1'b0);
            check("postrst_in_ready", bus.in_ready,  1'b1);
        end
        @(posedge clk);
        #1;

        // All opcodes, a=0xF0 b=0xCC, then RAND of 0xFF
        for (int i = 0; i < 8; i++)
            send(3'(i), 8'hF0, 8'hCC, pack(op_exp[i], (i == 7), 1'b0), c);
        send(3'd7, 8'hFF, 8'h00, pack(8'h01, 1'b0, 1'b1), c);
        idle();
        drain();

        // Latency and throughput: 8 back-to-back OR beats of a one-hot A
        acc0 = -1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    v = 8'(1) << i;
                    send(3'd1, v, 8'h00, pack(v, 1'b0, 1'b1), c);
                    if (i == 0) acc0 = c;
                end
                idle();
            end
            observe(t_first, run);
        join
        check("lat_first_valid", t_first - acc0, 32'd2);
        check("thru_run_len",    run,            32'd8);
        drain();

        // Backpressure: out_ready low for 5 cycles while offering 4 beats
        out_base      = n_out;
        bus.out_ready = 1'b0;
        k             = 0;
        acc           = 0;
        bus.in_valid  = 1'b1;
        bus.in_op     = 3'd2;
        bus.in_a      = bp_a[0];
        bus.in_b      = 8'h0F;
        for (int cy = 0; cy < 5; cy++) begin
            @(negedge clk);
            if (bus.out_valid) check("bp_hold", bus.out_result, 8'h1E);
            if (bus.in_ready) begin
                exp_q.push_back(pack(bp_res[k], 1'b0, 1'b0));
                acc++;
                k++;
            end
            @(posedge clk);
            #1;
            if (k < 4) bus.in_a = bp_a[k];
        end
        @(negedge clk);
        check("bp_accepted",     acc,            32'd2);
        check("bp_in_ready_low", bus.in_ready,   1'b0);
        check("bp_out_valid",    bus.out_valid,  1'b1);
        check("bp_out_result",   bus.out_result, 8'h1E);
        check("bp_out_zero",     bus.out_zero,   1'b0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        while (k < 4) begin
            send(3'd2, bp_a[k], 8'h0F, pack(bp_res[k], 1'b0, 1'b0), c);
            k++;
        end
        idle();
        drain();
        check("bp_out_count", n_out - out_base, 32'd4);

        // Flags
        send(3'd0, 8'hAA, 8'h55, pack(8'h00, 1'b1, 1'b0), c);
        send(3'd2, 8'hAA, 8'h55, pack(8'hFF, 1'b0, 1'b0), c);
        send(3'd1, 8'h07, 8'h00, pack(8'h07, 1'b0, 1'b1), c);
        idle();
        drain();

        // Random stress: random bubbles on input, random out_ready
        out_base = n_out;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                    r_op = 3'($urandom_range(0, 7));
                    r_a  = 8'($urandom_range(0, 255));
                    r_b  = 8'($urandom_range(0, 255));
                    send(r_op, r_a, r_b, model(r_op, r_a, r_b), c);
                end
                idle();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 1) == 1);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("rnd_out_count", n_out - out_base, 32'd10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
